song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter SONG_BITS, default 2, song-select width.
REQ-002 SHALL have parameter NOTE_ADDR_BITS, default 5, note-index width; each song holds 2^NOTE_ADDR_BITS entries.
REQ-003 SHALL have parameter NOTE_WIDTH, default 6, note-code width.
REQ-004 SHALL have parameter DURATION_WIDTH, default 6, duration width.
REQ-005 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- play  in  1  level run enable.
- song  in  SONG_BITS  song select, latched on leaving IDLE.
- reverse  in  1  1 = step addresses downward.
- ff  in  1  1 = halve presented duration.
- loop  in  1  1 = wrap at song boundary and keep playing.
- note_done  in  1  player finished current note.
- rom_addr  out  SONG_BITS+NOTE_ADDR_BITS  {latched song, note index}.
- rom_data  in  NOTE_WIDTH+DURATION_WIDTH  {note, duration}, valid one cycle after rom_addr.
- note  out  NOTE_WIDTH  presented note.
- duration  out  DURATION_WIDTH  presented duration.
- note_valid  out  1  note/duration valid.
- note_ready  in  1  consumer accepts note.
- song_done  out  1  one-cycle boundary pulse.
- playing  out  1  high in any state except IDLE.

Function
REQ-006 SHALL implement states IDLE, FETCH, LOAD, PRESENT, WAIT, ADVANCE.
REQ-007 IDLE: play=1 -> FETCH, latch song; song value differing from the previously latched song SHALL reset note index to 0.
REQ-008 FETCH -> LOAD unconditionally; rom_addr held stable.
REQ-009 LOAD -> PRESENT, registering note=rom_data[MSBs], duration=processed rom_data[LSBs].
REQ-010 Latency: play sampled at edge N SHALL give note_valid=1 after edge N+3.
REQ-011 PRESENT: note_valid=1 with note/duration held stable until note_valid&&note_ready, then -> WAIT; play deassertion SHALL NOT withdraw note_valid.
REQ-012 WAIT: note_done=1 -> ADVANCE (note_done wins over play=0 in the same cycle); else play=0 -> IDLE with index unchanged; else stay.
REQ-013 ADVANCE: index +1 (reverse=0) or -1 (reverse=1), modulo 2^NOTE_ADDR_BITS; reverse sampled in ADVANCE only.
REQ-014 Boundary = forward step from max index, or reverse step from 0; song_done SHALL pulse exactly one cycle after that edge, in both loop and non-loop modes.
REQ-015 Boundary with loop=0: index -> 0, next state IDLE, regardless of play.
REQ-016 Boundary with loop=1, or non-boundary: wrapped/stepped index; next state FETCH if play=1, else IDLE.
REQ-017 ff=1 (sampled in LOAD): duration = raw>>1, but raw=1 SHALL yield 1; raw=0 yields 0; ff=0 passes raw unchanged.
REQ-018 note code 0 (rest) SHALL be presented like any other note.
REQ-019 note_ready outside PRESENT and note_done outside WAIT SHALL be ignored.

Reset
REQ-020 reset low SHALL immediately force state IDLE, index 0, latched song 0, note 0, duration 0, note_valid 0, song_done 0, playing 0, rom_addr 0.
REQ-021 Reset assertion mid-operation (any state) SHALL abandon the note without further handshake.

Structure
REQ-022 State encodings and default parameter values SHALL reside in a shared package song_pkg.
REQ-023 All registers SHALL be in song_sequencer; no sub-module; ROM stays external.

Verification
REQ-024 Reset, song=1, reverse=0, play=1 at edge 0, rom_data=0x2C5 -> rom_addr=0x20, note_valid after edge 3, note=0x0B, duration=0x05, held until note_ready.
REQ-025 ff=1 with raw durations 9, 1, 0 -> presented 4, 1, 0.
REQ-026 loop=0, forward, index 31, note_done -> song_done pulse one cycle, playing=0, rom_addr index=0.
REQ-027 loop=1, reverse=1, song=2, index 0, note_done -> song_done pulse, rom_addr=0x5F, playing stays 1.
REQ-028 song=1 index 7, play=0 in WAIT, song=2, play=1 -> rom_addr=0x40; repeat with song unchanged -> rom_addr=0x27.
REQ-029 reset low during PRESENT with note_ready=0 -> note_valid=0 before next clock edge, all outputs at reset values.

Source files
------------

// File: rtl/song_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_pkg: shared state encodings and default parameter values    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package song_pkg;

  localparam int DEF_SONG_BITS      = 2;
  localparam int DEF_NOTE_ADDR_BITS = 5;
  localparam int DEF_NOTE_WIDTH     = 6;
  localparam int DEF_DURATION_WIDTH = 6;

  localparam int STATE_W = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;

endpackage : song_pkg
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | song_sequencer: steps through a song held in an external ROM and |
// | hands each note/duration to a player over a valid/ready port.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module song_sequencer
  import song_pkg::*;
#(
  parameter int SONG_BITS      = DEF_SONG_BITS,
  parameter int NOTE_ADDR_BITS = DEF_NOTE_ADDR_BITS,
  parameter int NOTE_WIDTH     = DEF_NOTE_WIDTH,
  parameter int DURATION_WIDTH = DEF_DURATION_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 play,
  input  logic [SONG_BITS-1:0]                 song,
  input  logic                                 reverse,
  input  logic                                 ff,
  input  logic                                 loop,
  input  logic                                 note_done,
  output logic [SONG_BITS+NOTE_ADDR_BITS-1:0]  rom_addr,
  input  logic [NOTE_WIDTH+DURATION_WIDTH-1:0] rom_data,
  output logic [NOTE_WIDTH-1:0]                note,
  output logic [DURATION_WIDTH-1:0]            duration,
  output logic                                 note_valid,
  input  logic                                 note_ready,
  output logic                                 song_done,
  output logic                                 playing
);

  localparam logic [NOTE_ADDR_BITS-1:0] LAST_INDEX = '1;

  logic [STATE_W-1:0]        r_state;
  logic [NOTE_ADDR_BITS-1:0] r_index;
  logic [SONG_BITS-1:0]      r_song;

  logic [NOTE_ADDR_BITS-1:0] w_index_step;
  logic                      w_boundary;
  logic [DURATION_WIDTH-1:0] w_raw_dur;
  logic [DURATION_WIDTH-1:0] w_dur;

  assign w_raw_dur = rom_data[DURATION_WIDTH-1:0];

  // Fast-forward halves the duration but never turns a 1 into a 0.
  always_comb begin
    w_dur = w_raw_dur;
    if (ff && (w_raw_dur != DURATION_WIDTH'(1))) begin
      w_dur = w_raw_dur >> 1;
    end
  end

  assign w_boundary   = reverse ? (r_index == '0) : (r_index == LAST_INDEX);
  assign w_index_step = reverse ? (r_index - NOTE_ADDR_BITS'(1))
                                : (r_index + NOTE_ADDR_BITS'(1));

  assign rom_addr = {r_song, r_index};
  assign playing  = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_song     <= '0;
      note       <= '0;
      duration   <= '0;
      note_valid <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      song_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (play) begin
            r_song  <= song;
            if (song != r_song) begin
              r_index <= '0;
            end
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          note     <= rom_data[NOTE_WIDTH+DURATION_WIDTH-1:DURATION_WIDTH];
          duration <= w_dur;
          r_state  <= S_PRESENT;
        end
        // note_valid rises on the first edge in PRESENT and drops on handshake.
        S_PRESENT: begin
          if (note_valid && note_ready) begin
            note_valid <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            note_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (note_done) begin
            r_state <= S_ADVANCE;
          end else if (!play) begin
            r_state <= S_IDLE;
          end
        end
        S_ADVANCE: begin
          if (w_boundary) begin
            song_done <= 1'b1;
          end
          if (w_boundary && !loop) begin
            r_index <= '0;
            r_state <= S_IDLE;
          end else begin
            r_index <= w_index_step;
            r_state <= play ? S_FETCH : S_IDLE;
          end
        end
        default: begin
          note_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule : song_sequencer
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_song_sequencer: directed stimulus with a note scoreboard      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_song_sequencer;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        reverse;
  logic        ff;
  logic        loop;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        note_valid;
  logic        note_ready;
  logic        song_done;
  logic        playing;

  int total = 0;
  int bad   = 0;

  logic [11:0] rom [0:127];
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;

  logic [5:0]  en [8];
  logic [5:0]  ed [8];
  logic        ft [8];

  song_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .reverse    (reverse),
    .ff         (ff),
    .loop       (loop),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .song_done  (song_done),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && note_valid && note_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_note: got 0x%0h expected none", {note, duration});
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_note", {26'd0, note}, {26'd0, exp_e[11:6]});
        check("sb_duration", {26'd0, duration}, {26'd0, exp_e[5:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take_note(input logic [5:0] n, input logic [5:0] d);
    int k = 0;
    while (!note_valid && k < 20) begin
      tick();
      k++;
    end
    if (!note_valid) begin
      total++;
      bad++;
      $display("FAIL note_timeout: got note_valid=0 expected 1");
    end else begin
      exp_q.push_back({n, d});
      note_ready = 1'b1;
      tick();
      note_ready = 1'b0;
    end
  endtask

  task automatic finish_note();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick();
    check("song_done_mid", {31'd0, song_done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'h000;
    rom[7'h20] = 12'h2C5;
    rom[7'h21] = 12'h049;
    rom[7'h22] = 12'h081;
    rom[7'h23] = 12'h000;
    rom[7'h24] = 12'hFFF;
    rom[7'h25] = 12'h186;
    rom[7'h26] = 12'h1C7;
    rom[7'h27] = 12'h208;
    rom[7'h40] = 12'h2A3;
    rom[7'h5F] = 12'h3D2;

    en[1] = 6'h01; ed[1] = 6'h04; ft[1] = 1'b1;
    en[2] = 6'h02; ed[2] = 6'h01; ft[2] = 1'b1;
    en[3] = 6'h00; ed[3] = 6'h00; ft[3] = 1'b1;
    en[4] = 6'h3F; ed[4] = 6'h3F; ft[4] = 1'b0;
    en[5] = 6'h06; ed[5] = 6'h06; ft[5] = 1'b0;
    en[6] = 6'h07; ed[6] = 6'h07; ft[6] = 1'b0;
    en[7] = 6'h08; ed[7] = 6'h08; ft[7] = 1'b0;
    en[0] = 6'h0B; ed[0] = 6'h05; ft[0] = 1'b0;

    reset = 1'b0; play = 1'b0; song = 2'd0; reverse = 1'b0; ff = 1'b0;
    loop = 1'b0; note_done = 1'b0; note_ready = 1'b0;
    #12;
    check("rst_note_valid", {31'd0, note_valid}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_song_done", {31'd0, song_done}, 32'd0);
    check("rst_note", {26'd0, note}, 32'd0);
    check("rst_duration", {26'd0, duration}, 32'd0);

    // Basic fetch latency on song 1, index 0.
    @(negedge clk);
    reset = 1'b1; song = 2'd1; play = 1'b1;
    tick();
    check("lat_rom_addr", {25'd0, rom_addr}, 32'h20);
    check("lat_playing", {31'd0, playing}, 32'd1);
    tick();
    check("lat_valid_e1", {31'd0, note_valid}, 32'd0);
    tick();
    check("lat_valid_e2", {31'd0, note_valid}, 32'd0);
    tick();
    check("lat_valid_e3", {31'd0, note_valid}, 32'd1);
    check("lat_note", {26'd0, note}, 32'h0B);
    check("lat_duration", {26'd0, duration}, 32'h05);
    play = 1'b0;
    tick();
    tick();
    check("hold_valid", {31'd0, note_valid}, 32'd1);
    check("hold_note", {26'd0, note}, 32'h0B);
    play = 1'b1;
    take_note(en[0], ed[0]);

    // Indices 1..7: fast-forward durations, a rest, full-scale codes.
    for (int i = 1; i < 8; i++) begin
      ff = ft[i];
      finish_note();
      take_note(en[i], ed[i]);
    end

    // Stop in WAIT keeps the index; same song resumes there.
    play = 1'b0;
    tick();
    check("stop_playing", {31'd0, playing}, 32'd0);
    check("stop_rom_addr", {25'd0, rom_addr}, 32'h27);
    play = 1'b1;
    tick();
    check("resume_rom_addr", {25'd0, rom_addr}, 32'h27);
    check("resume_playing", {31'd0, playing}, 32'd1);
    take_note(6'h08, 6'h08);
    play = 1'b0;
    tick();
    check("stop2_playing", {31'd0, playing}, 32'd0);
    song = 2'd2;
    play = 1'b1;
    tick();
    check("newsong_rom_addr", {25'd0, rom_addr}, 32'h40);
    take_note(6'h0A, 6'h23);

    // Reverse looping wrap from index 0.
    loop = 1'b1; reverse = 1'b1;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick();
    check("rwrap_song_done", {31'd0, song_done}, 32'd1);
    check("rwrap_playing", {31'd0, playing}, 32'd1);
    check("rwrap_rom_addr", {25'd0, rom_addr}, 32'h5F);
    tick();
    check("rwrap_pulse_end", {31'd0, song_done}, 32'd0);
    take_note(6'h0F, 6'h12);

    // Forward end of song without loop; note_done beats play=0.
    reverse = 1'b0; loop = 1'b0; play = 1'b0;
    note_done = 1'b1;
    tick();
    check("done_beats_stop", {31'd0, playing}, 32'd1);
    note_done = 1'b0;
    tick();
    check("end_song_done", {31'd0, song_done}, 32'd1);
    check("end_playing", {31'd0, playing}, 32'd0);
    check("end_rom_addr", {25'd0, rom_addr}, 32'h40);
    tick();
    check("end_pulse_end", {31'd0, song_done}, 32'd0);
    check("end_stays_idle", {31'd0, playing}, 32'd0);

    // Asynchronous reset while a note is presented and not accepted.
    play = 1'b1;
    begin
      int k = 0;
      while (!note_valid && k < 20) begin
        tick();
        k++;
      end
    end
    check("pre_reset_valid", {31'd0, note_valid}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("areset_note_valid", {31'd0, note_valid}, 32'd0);
    check("areset_playing", {31'd0, playing}, 32'd0);
    check("areset_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("areset_note", {26'd0, note}, 32'd0);
    check("areset_duration", {26'd0, duration}, 32'd0);
    check("areset_song_done", {31'd0, song_done}, 32'd0);
    #20;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_song_sequencer
`default_nettype wire
